// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffer and its stage wrappers.
// Occupancy doubles as the state encoding of the 2-entry skid buffer.
package pipe_pkg;

   localparam int PIPE_DATA_W = 128;
   localparam int PIPE_CTRL_W = 16;
   localparam int PIPE_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Shared by the performance-monitor counters.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register with 2-entry skid buffer, flush, bubble gating
// of control bits and a saturating stall counter.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid=0, in_ready=1
// ST_ONE   | head beat in main register, in_ready=1
// ST_FULL  | head in main, next beat in skid, in_ready=0
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int CNT_W  = PIPE_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   occ_state_e        state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              in_ready_q, in_ready_d;
   logic              push;
   logic              pop;

   assign out_valid = (state_q != ST_EMPTY);
   assign push      = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         // A coinciding pop has already been taken downstream; a push is dropped.
         state_d     = ST_EMPTY;
         main_data_d = '0;
         main_ctrl_d = '0;
         skid_data_d = '0;
         skid_ctrl_d = '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
                  state_d     = ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (push) begin
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
                  state_d     = ST_FULL;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  state_d     = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign occupancy = state_q;

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (out_valid & ~out_ready),
      .clr  (stall_clr),
      .count(stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: reset, streaming, backpressure, flush,
// bubble gating, stall counter saturation and reset mid-operation.
module tb_pipe_stage_buf;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;
   logic              stall_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   pipe_stage_buf #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ctrl (out_ctrl),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt),
      .stall_clr(stall_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = c;
   endtask

   initial begin
      // asynchronous reset, no clock edge yet
      #1 rst = 1'b1;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ctrl",  64'(out_ctrl),  64'd0);
      chk("rst_data",  64'(out_data),  64'd0);
      chk("rst_ready", 64'(in_ready),  64'd1);
      chk("rst_occ",   64'(occupancy), 64'd0);
      chk("rst_stall", 64'(stall_cnt), 64'd0);
      tick();
      tick();
      rst = 1'b0;

      // streaming
      out_ready = 1'b1;
      push_beat(32'h11, 16'h1);
      tick();
      chk("str_d11", 64'(out_data), 64'h11);
      chk("str_v",   64'(out_valid), 64'd1);
      chk("str_c",   64'(out_ctrl), 64'h1);
      push_beat(32'h22, 16'h2);
      tick();
      chk("str_d22", 64'(out_data), 64'h22);
      chk("str_rdy", 64'(in_ready), 64'd1);
      chk("str_occ", 64'(occupancy), 64'd1);
      push_beat(32'h33, 16'h3);
      tick();
      chk("str_d33", 64'(out_data), 64'h33);
      chk("str_occ3", 64'(occupancy), 64'd1);
      in_valid = 1'b0;
      tick();
      chk("drain_v",    64'(out_valid), 64'd0);
      chk("drain_ctrl", 64'(out_ctrl), 64'd0);
      chk("drain_hold", 64'(out_data), 64'h33);

      // backpressure
      out_ready = 1'b0;
      push_beat(32'hA, 16'hA);
      tick();
      chk("bp_occ1", 64'(occupancy), 64'd1);
      chk("bp_rdy1", 64'(in_ready), 64'd1);
      push_beat(32'hB, 16'hB);
      tick();
      in_valid = 1'b0;
      chk("bp_occ2",  64'(occupancy), 64'd2);
      chk("bp_rdy0",  64'(in_ready), 64'd0);
      chk("bp_headA", 64'(out_data), 64'hA);
      chk("bp_st1",   64'(stall_cnt), 64'd1);
      tick();
      chk("bp_holdA", 64'(out_data), 64'hA);
      chk("bp_ctrlA", 64'(out_ctrl), 64'hA);
      chk("bp_st2",   64'(stall_cnt), 64'd2);
      out_ready = 1'b1;
      tick();
      chk("bp_popB",  64'(out_data), 64'hB);
      chk("bp_rdy1b", 64'(in_ready), 64'd1);
      chk("bp_occ1b", 64'(occupancy), 64'd1);
      tick();
      chk("bp_empty", 64'(out_valid), 64'd0);
      chk("bp_stall", 64'(stall_cnt), 64'd2);

      // flush while FULL with an incoming beat
      out_ready = 1'b0;
      push_beat(32'hD, 16'hD);
      tick();
      push_beat(32'hE, 16'hE);
      tick();
      chk("fl_full", 64'(occupancy), 64'd2);
      push_beat(32'hC, 16'hC);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ctrl",  64'(out_ctrl), 64'd0);
      chk("fl_occ",   64'(occupancy), 64'd0);
      chk("fl_rdy",   64'(in_ready), 64'd1);
      chk("fl_data",  64'(out_data), 64'd0);
      chk("fl_stall", 64'(stall_cnt), 64'd4);
      // flush in EMPTY with an accepted-looking push: beat must be dropped
      push_beat(32'hC, 16'hC);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("fl_drop_v", 64'(out_valid), 64'd0);
      tick();
      chk("fl_noC_v", 64'(out_valid), 64'd0);
      chk("fl_noC_d", 64'(out_data), 64'd0);

      // bubble gating
      push_beat(32'h55, 16'hFFFF);
      tick();
      in_valid = 1'b0;
      chk("bub_ctrl1", 64'(out_ctrl), 64'hFFFF);
      tick();
      chk("bub_valid", 64'(out_valid), 64'd0);
      chk("bub_ctrl0", 64'(out_ctrl), 64'd0);
      chk("bub_data",  64'(out_data), 64'h55);

      // stall counter saturation, starting from 4
      out_ready = 1'b0;
      push_beat(32'h66, 16'h6);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("sat_14", 64'(stall_cnt), 64'd14);
      tick();
      chk("sat_15", 64'(stall_cnt), 64'd15);
      for (int i = 0; i < 9; i++) tick();
      chk("sat_hold", 64'(stall_cnt), 64'd15);
      chk("sat_data", 64'(out_data), 64'h66);
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      chk("clr_0", 64'(stall_cnt), 64'd0);
      tick();
      chk("clr_1", 64'(stall_cnt), 64'd1);

      // reset mid-operation
      #2 rst = 1'b1;
      #1;
      chk("mid_valid", 64'(out_valid), 64'd0);
      chk("mid_data",  64'(out_data), 64'd0);
      chk("mid_occ",   64'(occupancy), 64'd0);
      chk("mid_stall", 64'(stall_cnt), 64'd0);
      chk("mid_rdy",   64'(in_ready), 64'd1);
      tick();
      rst = 1'b0;
      tick();
      chk("post_valid", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries a generic payload (DATA_W bits: PC, instr, operands, ALU result) and a control bundle (CTRL_W bits: RegWrite, MemRead, MemWrite, WDSel and similar) between two stages.
- Handshake is valid/ready with a 2-entry skid buffer, so throughput is one beat per cycle with fully registered ready.
- Adds synchronous flush, bubble gating of control bits, occupancy output and a saturating stall counter for performance monitoring.

Parameters:
DATA_W, 128, payload width in bits
CTRL_W, 16, control bundle width; forced to zero whenever the output is not valid
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous flush; kills all held and incoming beats
in_valid  in  1  upstream beat valid
in_ready  out  1  buffer can accept a beat; registered
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
out_data  out  DATA_W  payload of the head beat
out_ctrl  out  CTRL_W  control of the head beat; 0 when out_valid=0
occupancy  out  2  held beats, 0..2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating
stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Storage: main register (head, drives out_*) and skid register. The state is encoded by occupancy: EMPTY(0), ONE(1), FULL(2).
- Reset (async, rst=1), applied immediately:
  - state EMPTY, in_ready=1, out_valid=0.
  - out_data=0, out_ctrl=0, skid contents=0, stall_cnt=0.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready is registered. It is 1 in EMPTY and ONE, 0 in FULL. Upstream must hold in_valid, in_data and in_ctrl stable until the beat is accepted.
- Transitions (no flush):
  - EMPTY: push loads main -> ONE.
  - ONE, push & pop: main <= in -> ONE.
  - ONE, push & !pop: skid <= in -> FULL, in_ready falls next cycle.
  - ONE, pop & !push -> EMPTY.
  - FULL, pop: main <= skid -> ONE, in_ready rises next cycle. No push is possible in FULL.
- Ordering is strictly FIFO. Latency is 1 cycle: a beat pushed at edge N is visible on out_* after edge N.
- Flush has priority over everything:
  - Next state is EMPTY. out_ctrl, main and skid are zeroed. in_ready becomes 1.
  - A push coinciding with flush is discarded.
  - A pop coinciding with flush completes; downstream consumed it in that cycle.
  - out_data is zeroed, matching the existing flush-to-NOP semantics.
- out_ctrl gating: the output is combinationally forced to 0 when out_valid=0, so a bubble is always a NOP.
- out_data holds its last value when not valid (except after reset or flush, where it is 0). out_data must not change while out_valid & !out_ready.
- stall_cnt:
  - Increments when out_valid & !out_ready, saturating at 2^CNT_W-1.
  - stall_clr has priority over increment and sets the counter to 0.
  - flush does not clear stall_cnt.
- Reset mid-operation: all held beats are lost, with no partial outputs.

Decomposition:
- Shared package pipe_pkg: occupancy state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2) and the default width constants reused by the stage wrappers.
- One sub-module: sat_counter (CNT_W parameter; inc, clr, count) for stall_cnt. It is reused by other performance counters.
- Per-stage wrappers pack and unpack named fields into in_data/in_ctrl. These wrappers are outside this block.

Test Plan:
- Reset check: assert rst with out_ready=0 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0, all immediately and without a clock edge.
- Streaming: out_ready=1; push 0x11, 0x22, 0x33 on consecutive cycles -> out_data shows 0x11, 0x22, 0x33 one cycle later each; in_ready stays 1; occupancy stays 1.
- Backpressure: out_ready=0; push A=0xA then B=0xB -> occupancy=2, in_ready=0, out_data=0xA held. Then raise out_ready -> A, then B delivered in order; in_ready=1 one cycle after the first pop; stall_cnt equals the number of stalled cycles.
- Flush when FULL, with a simultaneous push of 0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0xC never appears at the output.
- Bubble gating: in_ctrl=16'hFFFF pushed then popped with no further push -> out_ctrl=0 while out_valid=0.
- Counter: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Pulse stall_clr together with a stall cycle -> stall_cnt=0.
